// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard receiver.
//   state_t        : receiver FSM states (IDLE, RECV, CHECK)
//   PS2_EXT        : extended-key prefix byte (E0)
//   PS2_BRK        : break (key release) prefix byte (F0)
//   KEY_W          : width of one queued key event {ext, brk, code[7:0]}
//   odd_parity_ok  : 1 when data plus parity bit carry an odd number of ones
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam int         KEY_W   = 10;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ---------------------------------------------------------------------------
// ps2_fifo
// Synchronous show-ahead FIFO holding decoded key events.
//   clk, rst : system clock, asynchronous active-high reset
//   wr       : push wdata (dropped when full unless a pop happens this cycle)
//   wdata    : entry to push
//   rd       : pop the head entry (ignored when empty)
//   rdata    : head entry, valid whenever empty=0
//   empty    : no entries stored
//   full     : DEPTH entries stored
// Pointers carry one extra MSB so that full and empty are told apart when
// the lower bits are equal.
// ---------------------------------------------------------------------------
module ps2_fifo
   import ps2_pkg::*;
#(
   parameter int WIDTH = KEY_W,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees the slot at the same edge, so a full FIFO may accept a
   // simultaneous push.
   assign do_rd = rd & ~empty;
   assign do_wr = wr & (~full | do_rd);

   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately left out of reset; only the pointers
   // define which entries are meaningful, and a resettable array costs a
   // reset net per bit and blocks RAM inference.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver: conditions the raw keyboard lines, deframes 11-bit
// frames, folds E0/F0 prefixes into flags and queues key events.
//   clk       : system clock (25 MHz)
//   rst       : asynchronous active-high reset
//   ps2_clk   : raw keyboard clock (asynchronous)
//   ps2_data  : raw keyboard data (asynchronous)
//   key_rd    : pop the head key event (ignored when key_valid=0)
//   key_valid : at least one key event queued
//   key_data  : head event {ext, brk, code[7:0]}, show-ahead
//   raw_byte  : last byte of any good frame, prefixes included
//   frame_err : one-cycle pulse on parity, stop or timeout error
//   overflow  : sticky, set when a key event is dropped on a full queue
// ---------------------------------------------------------------------------
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   input  logic             key_rd,
   output logic             key_valid,
   output logic [KEY_W-1:0] key_data,
   output logic [7:0]       raw_byte,
   output logic             frame_err,
   output logic             overflow
);

   localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
   localparam int TCW = $clog2(TIMEOUT + 1);

   // ---------------- input conditioning ----------------
   logic [1:0]     clk_sync;
   logic [1:0]     data_sync;
   logic           clk_filt;
   logic           clk_filt_d;
   logic [FCW-1:0] filt_cnt;
   logic           sample_evt;
   logic           sample_bit;

   // Lines idle high, so the synchronisers and filter come out of reset at 1
   // and no false falling edge is seen after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         data_sync  <= {data_sync[0], ps2_data};
         clk_filt_d <= clk_filt;
         // Count consecutive samples that disagree with the filtered level;
         // any agreeing sample restarts the count.
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FCW'(1);
         end
      end
   end

   assign sample_evt = clk_filt_d & ~clk_filt;
   assign sample_bit = data_sync[1];

   // ---------------- deframing FSM ----------------
   state_t           state;
   state_t           state_n;
   logic [3:0]       bit_cnt;
   logic [9:0]       shreg;
   logic [TCW-1:0]   to_cnt;
   logic             ext;
   logic             brk;
   logic             push;
   logic             frame_good;
   logic [7:0]       rx_byte;
   logic             fifo_empty;
   logic             fifo_full;
   logic [KEY_W-1:0] fifo_rdata;

   // After ten shifts: [7:0] data (LSB first), [8] parity, [9] stop.
   assign rx_byte    = shreg[7:0];
   assign frame_good = odd_parity_ok(shreg[7:0], shreg[8]) & shreg[9];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // NOTE: every output of this block is given a default before the case,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_n   = state;
      push      = 1'b0;
      frame_err = 1'b0;
      unique case (state)
         IDLE: begin
            if (sample_evt && !sample_bit) state_n = RECV;
         end
         RECV: begin
            if (sample_evt) begin
               if (bit_cnt == 4'd9) state_n = CHECK;
            end else if (to_cnt == TCW'(TIMEOUT - 1)) begin
               frame_err = 1'b1;
               state_n   = IDLE;
            end
         end
         CHECK: begin
            state_n = IDLE;
            if (!frame_good)
               frame_err = 1'b1;
            else if (rx_byte != PS2_EXT && rx_byte != PS2_BRK)
               push = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         to_cnt   <= '0;
         ext      <= 1'b0;
         brk      <= 1'b0;
         raw_byte <= '0;
         overflow <= 1'b0;
      end else begin
         if (sample_evt)          to_cnt <= '0;
         else if (state == RECV)  to_cnt <= to_cnt + TCW'(1);

         if (state == IDLE)                    bit_cnt <= '0;
         else if (state == RECV && sample_evt) bit_cnt <= bit_cnt + 4'd1;

         if (state == RECV && sample_evt) shreg <= {sample_bit, shreg[9:1]};

         // Any error (bad frame or timeout) discards pending prefixes.
         if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (state == CHECK) begin
            raw_byte <= rx_byte;
            if (rx_byte == PS2_EXT)      ext <= 1'b1;
            else if (rx_byte == PS2_BRK) brk <= 1'b1;
            else begin
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end

         // A pop in the same cycle makes room, so only a pop-less push drops.
         if (push && fifo_full && !key_rd) overflow <= 1'b1;
      end
   end

   // ---------------- key event queue ----------------
   ps2_fifo #(
      .WIDTH (KEY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (push),
      .wdata ({ext, brk, rx_byte}),
      .rd    (key_rd),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign key_valid = ~fifo_empty;
   assign key_data  = fifo_empty ? '0 : fifo_rdata;

endmodule
